pd_peak_collector: RTL and testbench

Consumer end of the peak-detect output stream. Captures `peak_valid`/`peak_info` records from the moving-average/peak-detect datapath, tags each record with its pixel column, and buffers it in a synchronous FIFO. Host/AEX logic drains the FIFO through a valid/ready read port. The block sits directly downstream of the detector on the same pixel clock and shares its line-activity and column-start controls.

---
 rtl/pd_peak_collector.sv | 185 ++++++++++++++++++
 tb/tb_pd_peak_collector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pd_peak_collector.sv
// Peak-record collector: tags detector peaks with their pixel column and queues them for a valid/ready reader.
// Optional end-of-line marker records are enabled by defining PD_PEAK_COLLECT_EOL_MARKER_EN.
module pd_peak_collector #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TAG_OFFSET  = 0,
    parameter int unsigned DATAWIDTH   = 16,
    parameter int unsigned PIXEL_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_act,
    input  logic                             vald_din,
    input  logic [PIXEL_WIDTH-1:0]           active_columns_start,
    input  logic                             pdet_en,
    input  logic                             peak_valid,
    input  logic [DATAWIDTH-1:0]             peak_info,
    input  logic                             rd_ready,
    output logic                             rd_valid,
    output logic [DATAWIDTH-1:0]             rd_data,
    output logic [PIXEL_WIDTH-1:0]           rd_col,
    output logic                             rd_eol,
    input  logic                             clr_ovf,
    output logic                             ovf,
    output logic [7:0]                       drop_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             busy
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_EOL
    } state_t;

    state_t                 state_q, state_d;
    logic [PIXEL_WIDTH-1:0] col_q, col_d;
    logic [LW-1:0]          level_q, level_d;
    logic [AW-1:0]          wptr_q, rptr_q;
    logic                   ovf_q, ovf_d;
    logic [7:0]             drop_q, drop_d;

    logic [DATAWIDTH-1:0]   mem_data [FIFO_DEPTH];
    logic [PIXEL_WIDTH-1:0] mem_col  [FIFO_DEPTH];

    logic                   enter_act;
    logic                   peak_wr;
    logic                   marker_wr;
    logic                   wr_req;
    logic                   wr_acc;
    logic                   drop;
    logic                   pop;
    logic                   full;
    logic [DATAWIDTH-1:0]   wdata;
    logic [PIXEL_WIDTH-1:0] wcol;

`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
    logic [7:0]             lcnt_q;
    logic                   mem_eol [FIFO_DEPTH];
`endif

    always_comb begin
        state_d   = state_q;
        enter_act = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_act) begin
                    state_d   = ST_ACTIVE;
                    enter_act = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!start_act) state_d = ST_EOL;
            end
            ST_EOL: begin
                if (start_act) begin
                    state_d   = ST_ACTIVE;
                    enter_act = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d = col_q;
        if (enter_act)
            col_d = active_columns_start;
        else if (state_q == ST_ACTIVE && vald_din)
            col_d = col_q + 1'b1;
    end

    // The ACTIVE->EOL cycle still reports ST_ACTIVE, so a last-pixel peak lands one slot ahead of the marker.
    assign peak_wr = (state_q == ST_ACTIVE) && peak_valid && pdet_en;

`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
    assign marker_wr = (state_q == ST_EOL);
    assign wdata     = marker_wr ? DATAWIDTH'(lcnt_q) : peak_info;
    assign wcol      = marker_wr ? col_q : col_q - PIXEL_WIDTH'(TAG_OFFSET);
`else
    assign marker_wr = 1'b0;
    assign wdata     = peak_info;
    assign wcol      = col_q - PIXEL_WIDTH'(TAG_OFFSET);
`endif

    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign wr_req   = peak_wr || marker_wr;
    assign wr_acc   = wr_req && (!full || pop);
    assign drop     = wr_req && !wr_acc;
    assign level_d  = level_q + LW'(wr_acc) - LW'(pop);

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            if (wr_acc) wptr_q <= wptr_q + 1'b1;
            if (pop)    rptr_q <= rptr_q + 1'b1;
        end
    end

`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lcnt_q <= '0;
        else if (enter_act)
            lcnt_q <= '0;
        else if (peak_wr && lcnt_q != 8'hFF)
            lcnt_q <= lcnt_q + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_data[wptr_q] <= wdata;
            mem_col[wptr_q]  <= wcol;
`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
            mem_eol[wptr_q]  <= marker_wr;
`endif
        end
    end

    // Head slot is never rewritten until popped, so gating on rd_valid keeps outputs stable and zero when empty.
    assign rd_data    = rd_valid ? mem_data[rptr_q] : '0;
    assign rd_col     = rd_valid ? mem_col[rptr_q]  : '0;
`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
    assign rd_eol     = rd_valid ? mem_eol[rptr_q]  : 1'b0;
`else
    assign rd_eol     = 1'b0;
`endif
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != ST_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_pd_peak_collector.sv
// Directed self-checking bench for pd_peak_collector (default 16-deep FIFO, 16-bit data, 10-bit columns).
module tb_pd_peak_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_act;
    logic        vald_din;
    logic [9:0]  active_columns_start;
    logic        pdet_en;
    logic        peak_valid;
    logic [15:0] peak_info;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [9:0]  rd_col;
    logic        rd_eol;
    logic        clr_ovf;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic [4:0]  fifo_level;
    logic        busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pd_peak_collector #(
        .FIFO_DEPTH (16),
        .TAG_OFFSET (0),
        .DATAWIDTH  (16),
        .PIXEL_WIDTH(10)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_act           (start_act),
        .vald_din            (vald_din),
        .active_columns_start(active_columns_start),
        .pdet_en             (pdet_en),
        .peak_valid          (peak_valid),
        .peak_info           (peak_info),
        .rd_ready            (rd_ready),
        .rd_valid            (rd_valid),
        .rd_data             (rd_data),
        .rd_col              (rd_col),
        .rd_eol              (rd_eol),
        .clr_ovf             (clr_ovf),
        .ovf                 (ovf),
        .drop_cnt            (drop_cnt),
        .fifo_level          (fifo_level),
        .busy                (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, ".rd_data"},  32'(rd_data),  32'd0);
        chk({tag, ".rd_col"},   32'(rd_col),   32'd0);
        chk({tag, ".rd_eol"},   32'(rd_eol),   32'd0);
        chk({tag, ".ovf"},      32'(ovf),      32'd0);
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, ".level"},    32'(fifo_level), 32'd0);
        chk({tag, ".busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        reset = 1'b1; start_act = 1'b0; vald_din = 1'b0; active_columns_start = '0;
        pdet_en = 1'b0; peak_valid = 1'b0; peak_info = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        reset = 1'b0;

        // Line from column 10, peaks at the 3rd and 7th valid pixels, the second in the last active cycle.
        active_columns_start = 10'd10; start_act = 1'b1; vald_din = 1'b1; pdet_en = 1'b1; rd_ready = 1'b1;
        step();
        chk("line1.busy", 32'(busy), 32'd1);
        step(); step();
        peak_valid = 1'b1; peak_info = 16'h00AA;
        step();
        peak_valid = 1'b0;
        chk("pk1.valid", 32'(rd_valid), 32'd1);
        chk("pk1.col",   32'(rd_col),   32'd12);
        chk("pk1.data",  32'(rd_data),  32'h00AA);
        chk("pk1.eol",   32'(rd_eol),   32'd0);
        chk("pk1.level", 32'(fifo_level), 32'd1);
        step();
        chk("pk1.popped", 32'(rd_valid), 32'd0);
        step(); step();
        peak_valid = 1'b1; peak_info = 16'h00BB; start_act = 1'b0;
        step();
        peak_valid = 1'b0;
        chk("pk2.valid", 32'(rd_valid), 32'd1);
        chk("pk2.col",   32'(rd_col),   32'd16);
        chk("pk2.data",  32'(rd_data),  32'h00BB);
        step();
`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
        chk("mk1.valid", 32'(rd_valid), 32'd1);
        chk("mk1.eol",   32'(rd_eol),   32'd1);
        chk("mk1.data",  32'(rd_data),  32'd2);
        chk("mk1.col",   32'(rd_col),   32'd17);
        step();
`else
        chk("line1.noeol", 32'(rd_valid), 32'd0);
`endif
        chk("line1.empty", 32'(rd_valid), 32'd0);
        chk("line1.idle",  32'(busy),     32'd0);

        // Peaks while IDLE or with pdet_en low must not be stored.
        vald_din = 1'b0; peak_valid = 1'b1;
        step(); step();
        chk("idle.level", 32'(fifo_level), 32'd0);
        start_act = 1'b1; pdet_en = 1'b0;
        step(); step(); step();
        chk("pdet_off.level", 32'(fifo_level), 32'd0);
        chk("pdet_off.valid", 32'(rd_valid),   32'd0);
        peak_valid = 1'b0; pdet_en = 1'b1; start_act = 1'b0;
        step(); step(); step();
        chk("pdet_off.drain", 32'(fifo_level), 32'd0);

        // Overflow: 18 peaks into a 16-deep FIFO with the reader stalled.
        rd_ready = 1'b0; active_columns_start = 10'd0; start_act = 1'b1;
        step();
        for (int i = 0; i < 18; i++) begin
            peak_valid = 1'b1; peak_info = 16'(100 + i);
            step();
        end
        chk("ovf.level", 32'(fifo_level), 32'd16);
        chk("ovf.flag",  32'(ovf),        32'd1);
        chk("ovf.drops", 32'(drop_cnt),   32'd2);
        chk("ovf.head",  32'(rd_data),    32'd100);
        clr_ovf = 1'b1; peak_info = 16'd500;
        step();
        chk("clrdrop.ovf",   32'(ovf),      32'd1);
        chk("clrdrop.drops", 32'(drop_cnt), 32'd1);
        peak_valid = 1'b0;
        step();
        clr_ovf = 1'b0;
        chk("clr.ovf",   32'(ovf),      32'd0);
        chk("clr.drops", 32'(drop_cnt), 32'd0);

        // Full FIFO: push and pop in the same cycle must be accepted.
        peak_valid = 1'b1; peak_info = 16'd999; rd_ready = 1'b1;
        step();
        peak_valid = 1'b0;
        chk("fullpp.level", 32'(fifo_level), 32'd16);
        chk("fullpp.ovf",   32'(ovf),        32'd0);
        start_act = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("drain.data", 32'(rd_data), (i < 15) ? 32'(101 + i) : 32'd999);
            step();
        end
`ifdef PD_PEAK_COLLECT_EOL_MARKER_EN
        chk("mk2.eol",  32'(rd_eol),  32'd1);
        chk("mk2.data", 32'(rd_data), 32'd20);
        chk("mk2.col",  32'(rd_col),  32'd0);
        step();
`endif
        chk("drain.empty", 32'(rd_valid), 32'd0);

        // Column counter wraps from the maximum start value.
        active_columns_start = 10'h3FF; vald_din = 1'b1; start_act = 1'b1;
        step(); step(); step();
        peak_valid = 1'b1; peak_info = 16'h00CC;
        step();
        peak_valid = 1'b0;
        chk("wrap.col",  32'(rd_col),  32'd1);
        chk("wrap.data", 32'(rd_data), 32'h00CC);
        start_act = 1'b0; vald_din = 1'b0;
        step(); step(); step();

        // Asynchronous reset mid-line with five stored records.
        rd_ready = 1'b0; active_columns_start = 10'd5; start_act = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            peak_valid = 1'b1; peak_info = 16'(16 + i);
            step();
        end
        peak_valid = 1'b0;
        chk("pre_rst.level", 32'(fifo_level), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        peak_valid = 1'b1; peak_info = 16'h0077;
        step();
        peak_valid = 1'b0;
        chk("post_rst.level", 32'(fifo_level), 32'd1);
        chk("post_rst.data",  32'(rd_data),    32'h0077);
        chk("post_rst.col",   32'(rd_col),     32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
